mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

- Owns the single byte-wide RAM port and transfers whole cache lines over it.
- Arbitrates between the instruction-cache refill requester and the data-cache refill/write-back requester.
- Transfers one 16-byte line per grant, serialised one byte per cycle, and returns each refilled line in a shared line buffer.
- Sits between the two caches and the RAM/IO bus and honours the bus `readyIn` stall.

## Interface
- `ADDR_WIDTH`, 17, byte-address width.
- `BLOCK_WIDTH`, 4, log2 of line size in bytes.
- `BLOCK_SIZE`, 2**BLOCK_WIDTH, line size in bytes.
- `STARVE_LIMIT`, 4, consecutive I-side losses before I-side is forced to win (guard build only).
- `clkIn` in 1: the only clock; all logic on posedge.
- `resetIn` in 1: asynchronous, active-high reset.
- `readyIn` in 1: bus ready; low stalls the transfer.
- `memIn` in 8: RAM read data. It returns the address presented one cycle earlier.
- `memAddr` out ADDR_WIDTH: RAM byte address.
- `memOut` out 8: RAM write data.
- `readWriteOut` out 1: 1 = read, 0 = write.
- `icReq` in 1: I-side refill request (level).
- `icTag` in ADDR_WIDTH-BLOCK_WIDTH: I-side line tag.
- `dcReq` in 1: D-side request (level).
- `dcWrite` in 1: 1 = write-back, 0 = refill.
- `dcTag` in ADDR_WIDTH-BLOCK_WIDTH: D-side line tag.
- `dcWData` in BLOCK_SIZE*8: write-back line, byte k at bits [8k+7:8k].
- `lineOut` out BLOCK_SIZE*8: refilled line, same byte order.
- `icDone` out 1: I-side completion pulse.
- `dcDone` out 1: D-side completion pulse.
- `busy` out 1: FSM not IDLE.

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- Counter `cnt` is BLOCK_WIDTH+1 bits wide.
- IDLE, when `readyIn`=1 and any request is high:
  - Grant the winner.
  - Latch its tag (and `dcWData` on a write-back) into internal registers.
  - Record the owner, clear `cnt`, and go to READ, or to WRITE for a D-side write.
- Arbitration: D-side wins a tie by default.
  - Starve counter increments whenever `icReq` and `dcReq` are both high and D-side is granted; it saturates at STARVE_LIMIT.
  - When the counter equals STARVE_LIMIT, I-side wins the tie.
  - Counter clears on every I-side grant.
- READ, cnt = 0..BLOCK_SIZE:
  - While cnt < BLOCK_SIZE, drive `memAddr`={tag,cnt[BLOCK_WIDTH-1:0]} and `readWriteOut`=1.
  - While cnt ≥ 1, capture `memIn` into byte cnt-1 of the line buffer.
  - After cnt = BLOCK_SIZE, go to DONE.
- WRITE, cnt = 0..BLOCK_SIZE-1:
  - Drive `memAddr`={tag,cnt}, `memOut`=byte cnt of the latched data, `readWriteOut`=0.
  - After the last byte, go to DONE.
- DONE:
  - Pulse the owner's done for exactly one cycle; `readWriteOut`=1.
  - `lineOut` is valid during this cycle and is held until the next READ capture.
  - Next state: IDLE.
- Requester protocol:
  - Hold req and the operands stable until done.
  - Drop req in the cycle after done; IDLE therefore never re-grants a completed request.
- Stall, `readyIn`=0 in READ/WRITE:
  - State and `cnt` are frozen; no capture.
  - READ with cnt ≥ 1 presents {tag,cnt-1}, so the capture on resume is still correct.
  - WRITE forces `readWriteOut`=1 and holds `memAddr`/`memOut`.
- `readyIn`=0 in IDLE: no grant. `readyIn`=0 in DONE: no effect.
- Requests arriving while busy wait; they are not queued beyond their level.

## Timing
- Reset values:
  - `memAddr`=0, `memOut`=0, `readWriteOut`=1.
  - `icDone`=0, `dcDone`=0, `lineOut`=0, `busy`=0.
  - FSM in IDLE; starve counter = 0.
- Reset asserted mid-transfer: transfer aborts immediately, no done pulse, outputs return to reset values.
- Grant: request sampled in IDLE at cycle t → first address driven at t+1.
- Refill: READ for cycles t+1..t+BLOCK_SIZE+1; done at t+BLOCK_SIZE+2 (t+18 for 16 B).
- Write-back: done at t+BLOCK_SIZE+1 (t+17).
- Each stall cycle adds one cycle of latency.
- Back-to-back: the next grant can occur in the IDLE cycle immediately after DONE.
- Minimum one IDLE cycle between transfers.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined: starve counter and I-side forced win are active as above.
- Undefined: strict D-side priority; counter logic and `STARVE_LIMIT` are unused.

## Test plan
- Refill: `icReq`, `icTag`=0x123, RAM byte at addr a = a[7:0]:
  - addresses 0x1230..0x123F driven in order;
  - `icDone` at t+18;
  - `lineOut` byte k = 0x30+k.
- Write-back: `dcWrite`=1, `dcTag`=0x010, data bytes 0xA0+k:
  - 16 cycles with `readWriteOut`=0, `memAddr` 0x0100..0x010F, `memOut` 0xA0..0xAF;
  - `dcDone` at t+17.
- Tie, guard off: `icReq` and `dcReq` held high, D-side issuing new requests each time:
  - D-side wins every round; `icDone` never pulses.
- Tie, guard on, `STARVE_LIMIT`=4: four D-side grants, then an I-side grant; counter returns to 0.
- Stall: `readyIn` low for 3 cycles at refill cnt=5:
  - the line is still byte-correct;
  - done arrives at t+21;
  - no write strobe in a stalled WRITE.
- Reset asserted at write byte 7:
  - `readWriteOut`=1 and `busy`=0 immediately;
  - no done;
  - a new request is then served normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: owns the byte-wide RAM port and moves whole cache lines
// over it for the I-cache refill side and the D-cache refill/write-back side.
// One line per grant, one byte per cycle, honouring the bus readyIn stall.
// Optional feature macro: MEM_ARB_STARVE_GUARD_EN. When defined, the I-side
// wins a tie after STARVE_LIMIT consecutive losses. When undefined, the D-side
// always wins a tie.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 17,
  parameter int BLOCK_WIDTH  = 4,
  parameter int BLOCK_SIZE   = 2**BLOCK_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                               clkIn,
  input  logic                               resetIn,
  input  logic                               readyIn,
  input  logic [7:0]                         memIn,
  output logic [ADDR_WIDTH-1:0]              memAddr,
  output logic [7:0]                         memOut,
  output logic                               readWriteOut,
  input  logic                               icReq,
  input  logic [ADDR_WIDTH-BLOCK_WIDTH-1:0]  icTag,
  input  logic                               dcReq,
  input  logic                               dcWrite,
  input  logic [ADDR_WIDTH-BLOCK_WIDTH-1:0]  dcTag,
  input  logic [BLOCK_SIZE*8-1:0]            dcWData,
  output logic [BLOCK_SIZE*8-1:0]            lineOut,
  output logic                               icDone,
  output logic                               dcDone,
  output logic                               busy
);

  localparam int TAG_WIDTH = ADDR_WIDTH - BLOCK_WIDTH;
  localparam int LINE_BITS = BLOCK_SIZE * 8;

  localparam logic [BLOCK_WIDTH:0] CNT_ONE     = (BLOCK_WIDTH+1)'(1);
  localparam logic [BLOCK_WIDTH:0] CNT_FULL    = (BLOCK_WIDTH+1)'(BLOCK_SIZE);
  localparam logic [BLOCK_WIDTH:0] CNT_LAST_WR = (BLOCK_WIDTH+1)'(BLOCK_SIZE - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} stateT;
  typedef enum logic {OWNER_IC, OWNER_DC} ownerT;

  stateT                  state;
  ownerT                  owner;
  logic [BLOCK_WIDTH:0]   cnt;
  logic [BLOCK_WIDTH:0]   cntPrev;
  logic [BLOCK_WIDTH-1:0] capIdx;
  logic [TAG_WIDTH-1:0]   tag;
  logic [LINE_BITS-1:0]   wData;
  logic [LINE_BITS-1:0]   wShift;
  logic [LINE_BITS-1:0]   lineBuf;
  logic                   icWins;

  // A READ at cnt >= 1 captures the byte addressed one cycle earlier.
  assign cntPrev = cnt - CNT_ONE;
  assign capIdx  = cntPrev[BLOCK_WIDTH-1:0];
  assign wShift  = wData >> {cnt[BLOCK_WIDTH-1:0], 3'b000};

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int STARVE_WIDTH = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_WIDTH-1:0] STARVE_MAX = STARVE_WIDTH'(STARVE_LIMIT);
  localparam logic [STARVE_WIDTH-1:0] STARVE_ONE = STARVE_WIDTH'(1);

  logic [STARVE_WIDTH-1:0] starveCnt;

  // The I-side takes a tie once it has lost STARVE_LIMIT ties in a row.
  assign icWins = icReq && (!dcReq || (starveCnt == STARVE_MAX));
`else
  // Strict priority: the D-side always takes a tie.
  assign icWins = icReq && !dcReq;
`endif

  // Transfer FSM: grant, byte counter, latched operands and line capture.
  always_ff @(posedge clkIn or posedge resetIn) begin
    if (resetIn) begin
      state   <= IDLE;
      owner   <= OWNER_IC;
      cnt     <= '0;
      tag     <= '0;
      wData   <= '0;
      // NOTE: lineBuf is reset because lineOut must read zero out of reset;
      // a plain line store with no such requirement would skip the reset.
      lineBuf <= '0;
`ifdef MEM_ARB_STARVE_GUARD_EN
      starveCnt <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments here, so every branch sees the
      // pre-edge cnt/state, no matter in which order the statements appear.
      unique case (state)
        IDLE: begin
          if (readyIn && (icReq || dcReq)) begin
            cnt <= '0;
            if (icWins) begin
              owner <= OWNER_IC;
              tag   <= icTag;
              state <= READ;
`ifdef MEM_ARB_STARVE_GUARD_EN
              starveCnt <= '0;
`endif
            end else begin
              owner <= OWNER_DC;
              tag   <= dcTag;
              if (dcWrite) begin
                wData <= dcWData;
                state <= WRITE;
              end else begin
                state <= READ;
              end
`ifdef MEM_ARB_STARVE_GUARD_EN
              if (icReq && (starveCnt != STARVE_MAX)) begin
                starveCnt <= starveCnt + STARVE_ONE;
              end
`endif
            end
          end
        end
        READ: begin
          if (readyIn) begin
            if (cnt != '0) begin
              lineBuf[{capIdx, 3'b000} +: 8] <= memIn;
            end
            if (cnt == CNT_FULL) begin
              state <= DONE;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        WRITE: begin
          if (readyIn) begin
            if (cnt == CNT_LAST_WR) begin
              state <= DONE;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // RAM port decode; a stalled READ re-presents the previous byte address so
  // the capture on resume sees the right data, a stalled WRITE drops the strobe.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    memAddr      = '0;
    memOut       = '0;
    readWriteOut = 1'b1;
    unique case (state)
      READ: begin
        if (readyIn || (cnt == '0)) begin
          memAddr = {tag, cnt[BLOCK_WIDTH-1:0]};
        end else begin
          memAddr = {tag, capIdx};
        end
      end
      WRITE: begin
        memAddr      = {tag, cnt[BLOCK_WIDTH-1:0]};
        memOut       = wShift[7:0];
        readWriteOut = !readyIn;
      end
      default: begin
        memAddr      = '0;
      end
    endcase
  end

  assign lineOut = lineBuf;
  assign busy    = (state != IDLE);
  assign icDone  = (state == DONE) && (owner == OWNER_IC);
  assign dcDone  = (state == DONE) && (owner == OWNER_DC);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: refill, write-back, tie arbitration,
// readyIn stalls on both directions, and reset in the middle of a write-back.
// The RAM model returns the low address byte with one cycle of latency.
module tb_mem_port_arbiter;

  localparam int ADDR_WIDTH  = 17;
  localparam int BLOCK_WIDTH = 4;
  localparam int BLOCK_SIZE  = 16;
  localparam int TAG_WIDTH   = ADDR_WIDTH - BLOCK_WIDTH;
  localparam int LINE_BITS   = BLOCK_SIZE * 8;

  logic                  clkIn = 1'b0;
  logic                  resetIn;
  logic                  readyIn;
  logic [7:0]            memIn;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [7:0]            memOut;
  logic                  readWriteOut;
  logic                  icReq;
  logic [TAG_WIDTH-1:0]  icTag;
  logic                  dcReq;
  logic                  dcWrite;
  logic [TAG_WIDTH-1:0]  dcTag;
  logic [LINE_BITS-1:0]  dcWData;
  logic [LINE_BITS-1:0]  lineOut;
  logic                  icDone;
  logic                  dcDone;
  logic                  busy;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int writeCount  = 0;

  mem_port_arbiter #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .BLOCK_WIDTH (BLOCK_WIDTH),
    .BLOCK_SIZE  (BLOCK_SIZE),
    .STARVE_LIMIT(4)
  ) dut (
    .clkIn       (clkIn),
    .resetIn     (resetIn),
    .readyIn     (readyIn),
    .memIn       (memIn),
    .memAddr     (memAddr),
    .memOut      (memOut),
    .readWriteOut(readWriteOut),
    .icReq       (icReq),
    .icTag       (icTag),
    .dcReq       (dcReq),
    .dcWrite     (dcWrite),
    .dcTag       (dcTag),
    .dcWData     (dcWData),
    .lineOut     (lineOut),
    .icDone      (icDone),
    .dcDone      (dcDone),
    .busy        (busy)
  );

  always #5 clkIn = ~clkIn;

  always @(posedge clkIn) cyc <= cyc + 1;

  // RAM model: read data is the low byte of last cycle's address; write strobes are counted.
  always @(posedge clkIn or posedge resetIn) begin
    if (resetIn) begin
      memIn <= 8'h00;
    end else begin
      memIn <= memAddr[7:0];
      if (!readWriteOut) writeCount <= writeCount + 1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clkIn);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Steps until a done pulse is visible (bounded), then checks the latency from t0.
  task automatic waitDone(input string tag, input int t0, input int expLat);
    int n = 0;
    while (!(icDone || dcDone) && n < 40) begin
      step();
      n++;
    end
    check(tag, 128'(cyc - t0), 128'(expLat));
  endtask

  initial begin
    logic [LINE_BITS-1:0] expLine;
    logic [LINE_BITS-1:0] wLine;
    logic [TAG_WIDTH-1:0] expTag;
    logic                 expIc [6];
    int                   t0;
    int                   w0;
    int                   doneSeen;

`ifdef MEM_ARB_STARVE_GUARD_EN
    expIc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
    expIc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

    resetIn = 1'b1;
    readyIn = 1'b1;
    icReq   = 1'b0;
    icTag   = '0;
    dcReq   = 1'b0;
    dcWrite = 1'b0;
    dcTag   = '0;
    dcWData = '0;

    // Reset values
    repeat (2) @(posedge clkIn);
    #1;
    check("reset memAddr", 128'(memAddr), 128'(0));
    check("reset memOut", 128'(memOut), 128'(0));
    check("reset readWriteOut", 128'(readWriteOut), 128'(1));
    check("reset icDone", 128'(icDone), 128'(0));
    check("reset dcDone", 128'(dcDone), 128'(0));
    check("reset lineOut", 128'(lineOut), 128'(0));
    check("reset busy", 128'(busy), 128'(0));
    resetIn = 1'b0;
    step();

    // I-side refill of tag 0x123
    for (int k = 0; k < 16; k++) expLine[8*k +: 8] = 8'(8'h30 + k);
    icReq = 1'b1;
    icTag = 13'h123;
    t0 = cyc;
    step();
    for (int k = 0; k < 16; k++) begin
      check("refill addr", 128'(memAddr), 128'(17'h01230 + k));
      check("refill rw", 128'(readWriteOut), 128'(1));
      step();
    end
    check("refill no early done", 128'(icDone), 128'(0));
    check("refill busy", 128'(busy), 128'(1));
    step();
    check("refill done latency", 128'(cyc - t0), 128'(18));
    check("refill icDone", 128'(icDone), 128'(1));
    check("refill dcDone", 128'(dcDone), 128'(0));
    check("refill line", 128'(lineOut), 128'(expLine));
    icReq = 1'b0;
    step();
    check("refill done is a pulse", 128'(icDone), 128'(0));
    check("refill back idle", 128'(busy), 128'(0));

    // D-side write-back of tag 0x010
    for (int k = 0; k < 16; k++) wLine[8*k +: 8] = 8'(8'hA0 + k);
    dcReq   = 1'b1;
    dcWrite = 1'b1;
    dcTag   = 13'h010;
    dcWData = wLine;
    t0 = cyc;
    w0 = writeCount;
    step();
    for (int k = 0; k < 16; k++) begin
      check("wb rw", 128'(readWriteOut), 128'(0));
      check("wb addr", 128'(memAddr), 128'(17'h00100 + k));
      check("wb data", 128'(memOut), 128'(8'hA0 + k));
      step();
    end
    check("wb done latency", 128'(cyc - t0), 128'(17));
    check("wb dcDone", 128'(dcDone), 128'(1));
    check("wb icDone", 128'(icDone), 128'(0));
    check("wb strobes", 128'(writeCount - w0), 128'(16));
    check("wb line held", 128'(lineOut), 128'(expLine));
    dcReq = 1'b0;
    step();
    check("wb done is a pulse", 128'(dcDone), 128'(0));

    // Write-back of tag 0x020 with a two-cycle stall at byte 3
    for (int k = 0; k < 16; k++) wLine[8*k +: 8] = 8'(8'h50 + k);
    dcReq   = 1'b1;
    dcWrite = 1'b1;
    dcTag   = 13'h020;
    dcWData = wLine;
    t0 = cyc;
    w0 = writeCount;
    step();
    repeat (3) step();
    readyIn = 1'b0;
    settle();
    check("wb stall no strobe", 128'(readWriteOut), 128'(1));
    check("wb stall addr", 128'(memAddr), 128'(17'h00203));
    check("wb stall data", 128'(memOut), 128'(8'h53));
    step();
    check("wb stall2 no strobe", 128'(readWriteOut), 128'(1));
    check("wb stall2 addr", 128'(memAddr), 128'(17'h00203));
    step();
    readyIn = 1'b1;
    settle();
    check("wb resume strobe", 128'(readWriteOut), 128'(0));
    check("wb resume addr", 128'(memAddr), 128'(17'h00203));
    waitDone("wb stall done latency", t0, 19);
    check("wb stall dcDone", 128'(dcDone), 128'(1));
    check("wb stall strobes", 128'(writeCount - w0), 128'(16));
    dcReq   = 1'b0;
    dcWrite = 1'b0;
    step();

    // Refill of tag 0x2AB with a three-cycle stall at cnt = 5
    for (int k = 0; k < 16; k++) expLine[8*k +: 8] = 8'(8'hB0 + k);
    icReq = 1'b1;
    icTag = 13'h2AB;
    t0 = cyc;
    step();
    repeat (5) step();
    readyIn = 1'b0;
    settle();
    check("rd stall addr c1", 128'(memAddr), 128'(17'h02AB4));
    check("rd stall rw", 128'(readWriteOut), 128'(1));
    step();
    check("rd stall addr c2", 128'(memAddr), 128'(17'h02AB4));
    step();
    check("rd stall addr c3", 128'(memAddr), 128'(17'h02AB4));
    step();
    readyIn = 1'b1;
    settle();
    check("rd resume addr", 128'(memAddr), 128'(17'h02AB5));
    waitDone("rd stall done latency", t0, 21);
    check("rd stall icDone", 128'(icDone), 128'(1));
    check("rd stall line", 128'(lineOut), 128'(expLine));
    icReq = 1'b0;
    step();

    // Tie: both requesters held high for six rounds
    icReq   = 1'b1;
    icTag   = 13'h055;
    dcReq   = 1'b1;
    dcWrite = 1'b0;
    dcTag   = 13'h077;
    for (int r = 0; r < 6; r++) begin
      expTag = expIc[r] ? 13'h055 : 13'h077;
      t0 = cyc;
      step();
      check("tie grant addr", 128'(memAddr), 128'({expTag, 4'h0}));
      waitDone("tie done latency", t0, 18);
      check("tie icDone", 128'(icDone), 128'(expIc[r]));
      check("tie dcDone", 128'(dcDone), 128'(!expIc[r]));
      step();
    end
    icReq = 1'b0;
    dcReq = 1'b0;
    step();
    check("tie back idle", 128'(busy), 128'(0));

    // Reset at write-back byte 7
    for (int k = 0; k < 16; k++) wLine[8*k +: 8] = 8'(8'hC0 + k);
    dcReq   = 1'b1;
    dcWrite = 1'b1;
    dcTag   = 13'h030;
    dcWData = wLine;
    step();
    repeat (7) step();
    check("pre-reset addr", 128'(memAddr), 128'(17'h00307));
    check("pre-reset rw", 128'(readWriteOut), 128'(0));
    resetIn = 1'b1;
    settle();
    check("mid reset rw", 128'(readWriteOut), 128'(1));
    check("mid reset busy", 128'(busy), 128'(0));
    check("mid reset addr", 128'(memAddr), 128'(0));
    check("mid reset memOut", 128'(memOut), 128'(0));
    check("mid reset lineOut", 128'(lineOut), 128'(0));
    dcReq   = 1'b0;
    dcWrite = 1'b0;
    step();
    step();
    resetIn = 1'b0;
    doneSeen = 0;
    for (int n = 0; n < 20; n++) begin
      if (icDone || dcDone) doneSeen++;
      step();
    end
    check("no done after reset", 128'(doneSeen), 128'(0));

    // readyIn low in IDLE blocks the grant
    readyIn = 1'b0;
    icReq   = 1'b1;
    icTag   = 13'h123;
    step();
    step();
    check("no grant while not ready", 128'(busy), 128'(0));

    // Normal refill after the aborted transfer
    for (int k = 0; k < 16; k++) expLine[8*k +: 8] = 8'(8'h30 + k);
    readyIn = 1'b1;
    t0 = cyc;
    step();
    check("post-reset first addr", 128'(memAddr), 128'(17'h01230));
    waitDone("post-reset done latency", t0, 18);
    check("post-reset icDone", 128'(icDone), 128'(1));
    check("post-reset line", 128'(lineOut), 128'(expLine));
    icReq = 1'b0;
    step();
    check("post-reset idle", 128'(busy), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
